// File: rtl/pipeline_front_regs.sv
// PC register plus IF/ID and ID/EX pipeline registers of the 5-stage RV32I core,
// applying hazard-unit stall/flush controls, EX redirects and perf-debug event counters.
module pipeline_front_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 16,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              flush_id,
    input  logic              flush_ex,
    input  logic              branch_taken_ex,
    input  logic              jump_ex,
    input  logic [31:0]       target_ex,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       pc_if,
    output logic [31:0]       pc_id,
    output logic [31:0]       instr_id,
    output logic              valid_id,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic [4:0]        rd_id,
    input  logic [31:0]       rs1_data_id,
    input  logic [31:0]       rs2_data_id,
    input  logic [31:0]       imm_id,
    input  logic              mem_read_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    output logic [31:0]       pc_ex,
    output logic [4:0]        rs1_ex,
    output logic [4:0]        rs2_ex,
    output logic [4:0]        rd_ex,
    output logic [31:0]       rs1_data_ex,
    output logic [31:0]       rs2_data_ex,
    output logic [31:0]       imm_ex,
    output logic              mem_read_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic              valid_ex,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

    logic        redirect;
    logic [31:0] pc_next;

    assign redirect = branch_taken_ex | jump_ex;

    // Redirect outranks stall_if so a resolved branch/jump is never dropped.
    always_comb begin
        // NOTE: default first so every path assigns pc_next and no latch is inferred.
        pc_next = pc_if + 32'd4;
        if (redirect)
            pc_next = {target_ex[31:2], 2'b00};
        else if (stall_if)
            pc_next = pc_if;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
        if (!rst_n)
            pc_if <= RESET_PC;
        else
            pc_if <= pc_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_id) begin
            pc_id    <= '0;
            instr_id <= NOP;
            valid_id <= 1'b0;
        end else if (!stall_id) begin
            pc_id    <= pc_if;
            instr_id <= imem_rdata;
            valid_id <= 1'b1;
        end
    end

    // A bubble carries rd=0 and mem_read=0 so it never looks like a load to the hazard unit.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_ex) begin
            pc_ex       <= '0;
            rs1_ex      <= '0;
            rs2_ex      <= '0;
            rd_ex       <= '0;
            rs1_data_ex <= '0;
            rs2_data_ex <= '0;
            imm_ex      <= '0;
            mem_read_ex <= 1'b0;
            ctrl_ex     <= '0;
            valid_ex    <= 1'b0;
        end else begin
            pc_ex       <= pc_id;
            rs1_ex      <= rs1_id;
            rs2_ex      <= rs2_id;
            rd_ex       <= rd_id;
            rs1_data_ex <= rs1_data_id;
            rs2_data_ex <= rs2_data_id;
            imm_ex      <= imm_id;
            mem_read_ex <= mem_read_id & valid_id;
            ctrl_ex     <= valid_id ? ctrl_id : '0;
            valid_ex    <= valid_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_id && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (flush_id && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_front_regs.sv
// Self-checking bench for pipeline_front_regs: a spec-level model pushes expected register
// state into a scoreboard each cycle; feature tasks add targeted constant checks.
module tb_pipeline_front_regs;

    localparam int          CTRL_W   = 16;
    localparam int          CNT_W    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    logic stall_if, stall_id, flush_id, flush_ex, branch_taken_ex, jump_ex;
    logic [31:0] target_ex, imem_rdata;
    logic [31:0] pc_if, pc_id, instr_id;
    logic        valid_id;
    logic [4:0]  rs1_id, rs2_id, rd_id;
    logic [31:0] rs1_data_id, rs2_data_id, imm_id;
    logic        mem_read_id;
    logic [CTRL_W-1:0] ctrl_id;
    logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
    logic        mem_read_ex, valid_ex;
    logic [CTRL_W-1:0] ctrl_ex;
    logic [CNT_W-1:0]  stall_count, flush_count;

    typedef struct packed {
        logic [31:0]       pc_if;
        logic [31:0]       pc_id;
        logic [31:0]       instr_id;
        logic              valid_id;
        logic [31:0]       pc_ex;
        logic [4:0]        rs1_ex;
        logic [4:0]        rs2_ex;
        logic [4:0]        rd_ex;
        logic [31:0]       rs1_data_ex;
        logic [31:0]       rs2_data_ex;
        logic [31:0]       imm_ex;
        logic              mem_read_ex;
        logic [CTRL_W-1:0] ctrl_ex;
        logic              valid_ex;
        logic [CNT_W-1:0]  stall_count;
        logic [CNT_W-1:0]  flush_count;
    } state_t;

    state_t got;
    state_t model;
    state_t sb[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;

    function automatic logic [31:0] imem_pat(input logic [31:0] addr);
        return (addr ^ 32'h5A5A_0000) | 32'h0000_0003;
    endfunction

    always #5 clk = ~clk;

    assign imem_rdata = imem_pat(pc_if);
    assign got = {pc_if, pc_id, instr_id, valid_id, pc_ex, rs1_ex, rs2_ex, rd_ex,
                  rs1_data_ex, rs2_data_ex, imm_ex, mem_read_ex, ctrl_ex, valid_ex,
                  stall_count, flush_count};

    pipeline_front_regs #(.RESET_PC(RESET_PC), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
        .branch_taken_ex(branch_taken_ex), .jump_ex(jump_ex), .target_ex(target_ex),
        .imem_rdata(imem_rdata), .pc_if(pc_if), .pc_id(pc_id), .instr_id(instr_id),
        .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
        .mem_read_id(mem_read_id), .ctrl_id(ctrl_id), .pc_ex(pc_ex), .rs1_ex(rs1_ex),
        .rs2_ex(rs2_ex), .rd_ex(rd_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
        .imm_ex(imm_ex), .mem_read_ex(mem_read_ex), .ctrl_ex(ctrl_ex), .valid_ex(valid_ex),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic clear_ctrl();
        stall_if = 0; stall_id = 0; flush_id = 0; flush_ex = 0;
        branch_taken_ex = 0; jump_ex = 0; target_ex = $urandom;
    endtask

    task automatic rand_id();
        rs1_id = 5'($urandom); rs2_id = 5'($urandom); rd_id = 5'($urandom);
        rs1_data_id = $urandom; rs2_data_id = $urandom; imm_id = $urandom;
        mem_read_id = 1'($urandom); ctrl_id = CTRL_W'($urandom);
    endtask

    // Predict the post-edge state from the model and current inputs, clock once, then compare.
    task automatic cycle_sb(input string tag);
        state_t e, exp_s;
        e = model;
        if (!rst_n) begin
            e = '0;
            e.pc_if = RESET_PC;
            e.instr_id = NOP;
        end else begin
            if (branch_taken_ex || jump_ex) e.pc_if = {target_ex[31:2], 2'b00};
            else if (!stall_if)             e.pc_if = model.pc_if + 32'd4;
            if (flush_id) begin
                e.pc_id = 0; e.instr_id = NOP; e.valid_id = 0;
            end else if (!stall_id) begin
                e.pc_id = model.pc_if; e.instr_id = imem_pat(model.pc_if); e.valid_id = 1;
            end
            if (flush_ex) begin
                e.pc_ex = 0; e.rs1_ex = 0; e.rs2_ex = 0; e.rd_ex = 0; e.rs1_data_ex = 0;
                e.rs2_data_ex = 0; e.imm_ex = 0; e.mem_read_ex = 0; e.ctrl_ex = 0; e.valid_ex = 0;
            end else begin
                e.pc_ex = model.pc_id; e.rs1_ex = rs1_id; e.rs2_ex = rs2_id; e.rd_ex = rd_id;
                e.rs1_data_ex = rs1_data_id; e.rs2_data_ex = rs2_data_id; e.imm_ex = imm_id;
                e.mem_read_ex = model.valid_id ? mem_read_id : 1'b0;
                e.ctrl_ex = model.valid_id ? ctrl_id : '0;
                e.valid_ex = model.valid_id;
            end
            if (stall_id && model.stall_count != {CNT_W{1'b1}}) e.stall_count = model.stall_count + 1;
            if (flush_id && model.flush_count != {CNT_W{1'b1}}) e.flush_count = model.flush_count + 1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        exp_s = sb.pop_front();
        model = exp_s;
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL sb[%s] cycle %0d got %h want %h", tag, cyc, got, exp_s);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; clear_ctrl(); rand_id();
        cycle_sb("reset");
        checks++; if (pc_if !== RESET_PC) begin errors++; $display("FAIL reset_pc_if got %h want %h", pc_if, RESET_PC); end
        checks++; if (instr_id !== NOP) begin errors++; $display("FAIL reset_instr_id got %h want %h", instr_id, NOP); end
        checks++; if ({valid_id, valid_ex, mem_read_ex, rd_ex} !== 8'h0) begin errors++; $display("FAIL reset_valids got %b%b%b rd %0d want 0", valid_id, valid_ex, mem_read_ex, rd_ex); end
        checks++; if ({stall_count, flush_count} !== '0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", stall_count, flush_count); end
        rst_n = 1;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 4; i++) begin
            clear_ctrl(); rand_id();
            cycle_sb("free_run");
            checks++; if (pc_if !== 32'(4 * (i + 1))) begin errors++; $display("FAIL free_pc_if got %h want %h", pc_if, 32'(4 * (i + 1))); end
            checks++; if (pc_id !== 32'(4 * i)) begin errors++; $display("FAIL free_pc_id got %h want %h", pc_id, 32'(4 * i)); end
            checks++; if (valid_ex !== (i >= 1)) begin errors++; $display("FAIL free_valid_ex got %b want %b", valid_ex, i >= 1); end
            if (i >= 1) begin
                checks++; if (pc_ex !== 32'(4 * (i - 1))) begin errors++; $display("FAIL free_pc_ex got %h want %h", pc_ex, 32'(4 * (i - 1))); end
            end
        end
    endtask

    task automatic test_load_use();
        clear_ctrl(); rand_id();
        stall_if = 1; stall_id = 1; flush_ex = 1; rd_id = 5'd7; mem_read_id = 1;
        cycle_sb("load_use");
        checks++; if (pc_if !== 32'h10) begin errors++; $display("FAIL lu_pc_if got %h want %h", pc_if, 32'h10); end
        checks++; if (pc_id !== 32'h0C || instr_id !== imem_pat(32'h0C)) begin errors++; $display("FAIL lu_ifid_hold got %h/%h want %h/%h", pc_id, instr_id, 32'h0C, imem_pat(32'h0C)); end
        checks++; if ({valid_ex, rd_ex, mem_read_ex} !== 7'h0) begin errors++; $display("FAIL lu_bubble got v%b rd%0d mr%b want 0", valid_ex, rd_ex, mem_read_ex); end
        checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_stall_count got %0d want 1", stall_count); end
        clear_ctrl(); rand_id();
        cycle_sb("load_use_release");
        checks++; if (pc_id !== 32'h10 || pc_if !== 32'h14) begin errors++; $display("FAIL lu_release got %h/%h want 10/14", pc_id, pc_if); end
    endtask

    task automatic test_redirect();
        clear_ctrl(); rand_id();
        jump_ex = 1; target_ex = 32'h0000_0203; flush_id = 1; flush_ex = 1;
        cycle_sb("redirect");
        checks++; if (pc_if !== 32'h200) begin errors++; $display("FAIL rd_pc_if got %h want %h", pc_if, 32'h200); end
        checks++; if (instr_id !== NOP || valid_id !== 1'b0 || pc_id !== 32'h0) begin errors++; $display("FAIL rd_ifid_bubble got %h v%b pc %h", instr_id, valid_id, pc_id); end
        checks++; if (valid_ex !== 1'b0) begin errors++; $display("FAIL rd_valid_ex got %b want 0", valid_ex); end
        checks++; if (flush_count !== 4'd1) begin errors++; $display("FAIL rd_flush_count got %0d want 1", flush_count); end
        clear_ctrl(); rand_id(); mem_read_id = 1; ctrl_id = '1;
        cycle_sb("redirect_after");
        checks++; if (pc_if !== 32'h204 || pc_id !== 32'h200 || valid_id !== 1'b1) begin errors++; $display("FAIL rd_refetch got %h/%h v%b", pc_if, pc_id, valid_id); end
        checks++; if (mem_read_ex !== 1'b0 || ctrl_ex !== '0 || valid_ex !== 1'b0) begin errors++; $display("FAIL rd_invalid_gating got mr%b ctrl %h v%b want 0", mem_read_ex, ctrl_ex, valid_ex); end
    endtask

    task automatic test_conflicts();
        clear_ctrl(); rand_id();
        branch_taken_ex = 1; stall_if = 1; flush_id = 1; stall_id = 1; target_ex = 32'h80;
        cycle_sb("conflicts");
        checks++; if (pc_if !== 32'h80) begin errors++; $display("FAIL cf_pc_if got %h want %h", pc_if, 32'h80); end
        checks++; if (instr_id !== NOP || valid_id !== 1'b0) begin errors++; $display("FAIL cf_ifid got %h v%b want bubble", instr_id, valid_id); end
        checks++; if (stall_count !== 4'd2 || flush_count !== 4'd2) begin errors++; $display("FAIL cf_counts got %0d/%0d want 2/2", stall_count, flush_count); end
    endtask

    task automatic test_wrap_and_saturate();
        clear_ctrl(); rand_id();
        jump_ex = 1; target_ex = 32'hFFFF_FFFF;
        cycle_sb("wrap_redirect");
        checks++; if (pc_if !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got %h want FFFFFFFC", pc_if); end
        clear_ctrl(); rand_id();
        cycle_sb("wrap");
        checks++; if (pc_if !== 32'h0) begin errors++; $display("FAIL wrap_pc_if got %h want 0", pc_if); end
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            clear_ctrl(); rand_id(); stall_id = 1; flush_id = 1;
            cycle_sb("saturate");
        end
        checks++; if (stall_count !== 4'hF || flush_count !== 4'hF) begin errors++; $display("FAIL sat_counts got %0d/%0d want 15/15", stall_count, flush_count); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            clear_ctrl(); rand_id();
            cycle_sb("prefill");
        end
        checks++; if (valid_ex !== 1'b1) begin errors++; $display("FAIL mr_prefill got valid_ex %b want 1", valid_ex); end
        rand_id();
        rst_n = 0; stall_if = 1; stall_id = 1; flush_id = 1; flush_ex = 1;
        jump_ex = 1; branch_taken_ex = 1; target_ex = 32'h40;
        cycle_sb("mid_reset");
        checks++; if (pc_if !== RESET_PC || pc_id !== 32'h0 || instr_id !== NOP) begin errors++; $display("FAIL mr_if got %h/%h/%h", pc_if, pc_id, instr_id); end
        checks++; if ({valid_id, valid_ex, mem_read_ex, rd_ex, ctrl_ex, pc_ex} !== '0) begin errors++; $display("FAIL mr_ex got v%b%b mr%b rd%0d ctrl %h pc %h", valid_id, valid_ex, mem_read_ex, rd_ex, ctrl_ex, pc_ex); end
        checks++; if (stall_count !== '0 || flush_count !== '0) begin errors++; $display("FAIL mr_counts got %0d/%0d want 0/0", stall_count, flush_count); end
        rst_n = 1; clear_ctrl(); rand_id();
        cycle_sb("post_reset");
        checks++; if (pc_if !== RESET_PC + 32'd4) begin errors++; $display("FAIL mr_restart got %h want %h", pc_if, RESET_PC + 32'd4); end
    endtask

    initial begin
        model = '0;
        test_reset();
        test_free_run();
        test_load_use();
        test_redirect();
        test_conflicts();
        test_wrap_and_saturate();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
